// File: rtl/rf_sort_sequencer_pkg.sv
// Shared definitions for the register-file sort sequencer and its neighbours
// (RegisterFile, Controller). Holds the default bus widths, the sort
// direction encodings and the sequencer state type.
package rf_sort_sequencer_pkg;

  // Default widths: 8-entry x 4-bit register file, swap count up to 28.
  localparam int SORT_ADDR_W = 3;
  localparam int SORT_DATA_W = 4;
  localparam int SORT_CNT_W  = 5;

  // Encodings of the 'descending' request bit.
  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    SWAP_A,
    SWAP_B,
    DONE
  } sort_state_t;

endpackage

// File: rtl/rf_sort_sequencer_if.sv
// Bundle of the sort sequencer's request/status signals and its view of the
// register file's two read ports and one write port.
//   slave  : the sequencer (takes the request, drives RF addresses/writes)
//   master : the Controller + register file side
interface rf_sort_sequencer_if
  import rf_sort_sequencer_pkg::*;
#(
  parameter int ADDR_W = SORT_ADDR_W,
  parameter int DATA_W = SORT_DATA_W,
  parameter int CNT_W  = SORT_CNT_W
);

  logic              start;
  logic              descending;
  logic [ADDR_W-1:0] lo_addr;
  logic [ADDR_W-1:0] hi_addr;
  logic [ADDR_W-1:0] rd_ad1;
  logic [ADDR_W-1:0] rd_ad2;
  logic [DATA_W-1:0] rd_d1;
  logic [DATA_W-1:0] rd_d2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  swap_cnt;

  modport slave (
    input  start, descending, lo_addr, hi_addr, rd_d1, rd_d2,
    output rd_ad1, rd_ad2, wr_en, wr_addr, wr_data, busy, done, swap_cnt
  );

  modport master (
    output start, descending, lo_addr, hi_addr, rd_d1, rd_d2,
    input  rd_ad1, rd_ad2, wr_en, wr_addr, wr_data, busy, done, swap_cnt
  );

endinterface

// File: rtl/rf_sort_sequencer_order_cmp.sv
// Combinational ordering test for one adjacent pair of register values.
// Ports:
//   a_i, b_i        : values at idx and idx+1 (unsigned)
//   descending_i    : requested direction (DIR_ASC / DIR_DESC)
//   out_of_order_o  : 1 when the pair must be swapped; equal values never swap
module sort_order_cmp
  import rf_sort_sequencer_pkg::*;
#(
  parameter int DATA_W = SORT_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              descending_i,
  output logic              out_of_order_o
);

  // Strict comparisons keep equal elements where they are.
  always_comb begin
    if (descending_i == DIR_DESC) begin
      out_of_order_o = (a_i < b_i);
    end else begin
      out_of_order_o = (a_i > b_i);
    end
  end

endmodule

// File: rtl/rf_sort_sequencer.sv
// In-place bubble sort (with early exit) of RF[lo..hi], ascending or
// descending. While busy the sequencer owns both RF read ports and the
// write port; a swap takes two write cycles (SWAP_A writes idx, SWAP_B
// writes idx+1).
// Ports:
//   CLK, reset : clock, asynchronous active-high reset
//   bus        : slave side of rf_sort_sequencer_if (request, RF ports,
//                busy/done status, swap counter)
module rf_sort_sequencer
  import rf_sort_sequencer_pkg::*;
#(
  parameter int ADDR_W = SORT_ADDR_W,
  parameter int DATA_W = SORT_DATA_W,
  parameter int CNT_W  = SORT_CNT_W
) (
  input logic                CLK,
  input logic                reset,
  rf_sort_sequencer_if.slave bus
);

  sort_state_t       state_q;
  logic [ADDR_W-1:0] idx_q, limit_q, lo_q;
  logic              dir_q, swapped_q;
  logic [DATA_W-1:0] a_q;
  logic [ADDR_W-1:0] rdAd1_q, rdAd2_q, wrAddr_q;
  logic [DATA_W-1:0] wrData_q;
  logic              wrEn_q, busy_q, done_q;
  logic [CNT_W-1:0]  swapCnt_q;

  logic              outOfOrder;
  logic [ADDR_W-1:0] idxInc;
  logic              swappedEff;
  logic              passEnd;
  logic              sortEnd;
  logic              doAdvance;
  logic [ADDR_W-1:0] idx_d, limit_d;
  logic              swapped_d;

  sort_order_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a_i            (bus.rd_d1),
    .b_i            (bus.rd_d2),
    .descending_i   (dir_q),
    .out_of_order_o (outOfOrder)
  );

  // Advance decision shared by an in-order COMPARE and by SWAP_B. In SWAP_B
  // the pair just swapped counts as a swap in this pass even though
  // swapped_q has not been updated yet. A pass that ends with the limit one
  // above lo has nothing left to compare, so the sort stops there.
  always_comb begin
    idxInc     = idx_q + ADDR_W'(1);
    swappedEff = (state_q == SWAP_B) || swapped_q;
    passEnd    = !(idxInc < limit_q);
    sortEnd    = !swappedEff || ((limit_q - ADDR_W'(1)) == lo_q);
    doAdvance  = ((state_q == COMPARE) && !outOfOrder) || (state_q == SWAP_B);
    idx_d      = passEnd ? lo_q : idxInc;
    limit_d    = passEnd ? (limit_q - ADDR_W'(1)) : limit_q;
    swapped_d  = passEnd ? 1'b0 : swappedEff;
  end

  // Sequencer FSM. All outputs are registered and set for the state being
  // entered, so the RF addresses never depend combinationally on start.
  // wr_data for SWAP_A is captured straight from rd_d2 in COMPARE, which
  // doubles as the latch of the second element.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      limit_q   <= '0;
      lo_q      <= '0;
      dir_q     <= DIR_ASC;
      swapped_q <= 1'b0;
      a_q       <= '0;
      rdAd1_q   <= '0;
      rdAd2_q   <= '0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      wrEn_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      swapCnt_q <= '0;
    end else begin
      wrEn_q <= 1'b0;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (bus.start) begin
            lo_q      <= bus.lo_addr;
            limit_q   <= bus.hi_addr;
            dir_q     <= bus.descending;
            idx_q     <= bus.lo_addr;
            swapped_q <= 1'b0;
            swapCnt_q <= '0;
            if (bus.lo_addr >= bus.hi_addr) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= COMPARE;
              busy_q  <= 1'b1;
              rdAd1_q <= bus.lo_addr;
              rdAd2_q <= bus.lo_addr + ADDR_W'(1);
            end
          end
        end

        COMPARE: begin
          if (outOfOrder) begin
            a_q      <= bus.rd_d1;
            state_q  <= SWAP_A;
            wrEn_q   <= 1'b1;
            wrAddr_q <= idx_q;
            wrData_q <= bus.rd_d2;
          end
        end

        SWAP_A: begin
          state_q  <= SWAP_B;
          wrEn_q   <= 1'b1;
          wrAddr_q <= idxInc;
          wrData_q <= a_q;
        end

        SWAP_B: begin
          swapped_q <= 1'b1;
          swapCnt_q <= swapCnt_q + CNT_W'(1);
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (doAdvance) begin
        if (passEnd && sortEnd) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          state_q   <= COMPARE;
          idx_q     <= idx_d;
          limit_q   <= limit_d;
          swapped_q <= swapped_d;
          rdAd1_q   <= idx_d;
          rdAd2_q   <= idx_d + ADDR_W'(1);
        end
      end
    end
  end

  assign bus.rd_ad1   = rdAd1_q;
  assign bus.rd_ad2   = rdAd2_q;
  assign bus.wr_en    = wrEn_q;
  assign bus.wr_addr  = wrAddr_q;
  assign bus.wr_data  = wrData_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.swap_cnt = swapCnt_q;

endmodule

// File: tb/tb_rf_sort_sequencer.sv
// Bench for rf_sort_sequencer: a behavioural 8x4 register file, a table of
// sort requests with hand-computed results, and directed sequences for
// reset mid-sort and a start held high across a whole sort.
module tb_rf_sort_sequencer;
  import rf_sort_sequencer_pkg::*;

  logic CLK = 1'b0;
  logic reset = 1'b0;

  rf_sort_sequencer_if bus ();

  rf_sort_sequencer dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz-style free-running clock.
  always #5 CLK = ~CLK;

  logic [3:0]  rf [8];
  logic        loadEn = 1'b0;
  logic [31:0] loadVal = '0;

  // Register file model: bulk load from the bench, otherwise the DUT write port.
  always @(posedge CLK) begin
    if (loadEn) begin
      for (int i = 0; i < 8; i++) rf[i] <= loadVal[4*i +: 4];
    end else if (bus.wr_en) begin
      rf[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.rd_d1 = rf[bus.rd_ad1];
  assign bus.rd_d2 = rf[bus.rd_ad2];

  int checks = 0;
  int failures = 0;

  int runCycles, runWrites, runOutOfRange, runBusyBad;
  logic doneAfter;

  typedef struct {
    string       name;
    logic [31:0] init;
    logic [2:0]  lo;
    logic [2:0]  hi;
    logic        desc;
    logic [31:0] expRf;
    int          swaps;
    int          cycles;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] rfPacked();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = rf[i];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] outVector();
    return 32'({bus.rd_ad1, bus.rd_ad2, bus.wr_en, bus.wr_addr, bus.wr_data,
                bus.busy, bus.done, bus.swap_cnt});
  endfunction

  task automatic loadRf(input logic [31:0] v);
    @(negedge CLK);
    loadEn  = 1'b1;
    loadVal = v;
    @(posedge CLK);
    #1 loadEn = 1'b0;
  endtask

  // Issue one request and follow it to its done pulse, recording latency,
  // writes, out-of-range writes and busy misbehaviour. Leaves the bench at
  // the negedge of the cycle after done.
  task automatic applyStimulus(input logic [2:0] lo, input logic [2:0] hi,
                               input logic desc, input bit holdStart);
    bit finished;
    @(negedge CLK);
    bus.lo_addr    = lo;
    bus.hi_addr    = hi;
    bus.descending = desc;
    bus.start      = 1'b1;
    @(posedge CLK);
    #1 if (!holdStart) bus.start = 1'b0;
    runCycles = -1;
    runWrites = 0;
    runOutOfRange = 0;
    runBusyBad = 0;
    finished = 0;
    for (int k = 1; k <= 400 && !finished; k++) begin
      @(negedge CLK);
      if (bus.done) begin
        runCycles = k;
        finished = 1;
        if (bus.busy) runBusyBad++;
      end else begin
        if (!bus.busy) runBusyBad++;
        if (bus.wr_en) begin
          runWrites++;
          if (bus.wr_addr < lo || bus.wr_addr > hi) runOutOfRange++;
        end
      end
    end
    @(negedge CLK);
    doneAfter = bus.done;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.descending = 1'b0;
    bus.lo_addr    = '0;
    bus.hi_addr    = '0;

    vecs[0] = '{"sorted_asc",   32'h87654321, 3'd0, 3'd7, 1'b0, 32'h87654321, 0,  8};
    vecs[1] = '{"reversed_asc", 32'h12345678, 3'd0, 3'd7, 1'b0, 32'h87654321, 28, 85};
    vecs[2] = '{"sub_desc",     32'h27139365, 3'd2, 3'd5, 1'b1, 32'h27133965, 1,  8};
    vecs[3] = '{"lo_eq_hi",     32'hABCDEF01, 3'd4, 3'd4, 1'b0, 32'hABCDEF01, 0,  1};
    vecs[4] = '{"lo_gt_hi",     32'hABCDEF01, 3'd6, 3'd2, 1'b1, 32'hABCDEF01, 0,  1};
    vecs[5] = '{"small_asc",    32'h99992314, 3'd0, 3'd3, 1'b0, 32'h99994321, 4,  15};
    vecs[6] = '{"equal_desc",   32'h00000555, 3'd0, 3'd2, 1'b1, 32'h00000555, 0,  3};
    vecs[7] = '{"top_pair",     32'h19000000, 3'd6, 3'd7, 1'b0, 32'h91000000, 1,  4};

    // Reset state.
    #1 reset = 1'b1;
    #10;
    checkOutput("reset_outputs", outVector(), 32'h0);
    @(negedge CLK);
    reset = 1'b0;

    // Table-driven sorts.
    for (int v = 0; v < 8; v++) begin
      loadRf(vecs[v].init);
      applyStimulus(vecs[v].lo, vecs[v].hi, vecs[v].desc, 1'b0);
      checkOutput({vecs[v].name, "_cycles"}, 32'(runCycles), 32'(vecs[v].cycles));
      checkOutput({vecs[v].name, "_swapcnt"}, 32'(bus.swap_cnt), 32'(vecs[v].swaps));
      checkOutput({vecs[v].name, "_rf"}, rfPacked(), vecs[v].expRf);
      checkOutput({vecs[v].name, "_writes"}, 32'(runWrites), 32'(2 * vecs[v].swaps));
      checkOutput({vecs[v].name, "_wr_range"}, 32'(runOutOfRange), 32'h0);
      checkOutput({vecs[v].name, "_busy"}, 32'(runBusyBad), 32'h0);
      checkOutput({vecs[v].name, "_done_pulse"}, 32'(doneAfter), 32'h0);
    end

    // Reset ten cycles into a reversed full-range sort, then re-sort.
    loadRf(32'h12345678);
    @(negedge CLK);
    bus.lo_addr = 3'd0;
    bus.hi_addr = 3'd7;
    bus.descending = 1'b0;
    bus.start = 1'b1;
    @(posedge CLK);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge CLK);
    checkOutput("abort_swapcnt_before", 32'(bus.swap_cnt), 32'd3);
    #1 reset = 1'b1;
    #1 checkOutput("abort_outputs", outVector(), 32'h0);
    checkOutput("abort_rf_partial", rfPacked(), 32'h12348567);
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    checkOutput("abort_idle", 32'({bus.busy, bus.done, bus.wr_en}), 32'h0);
    applyStimulus(3'd0, 3'd7, 1'b0, 1'b0);
    checkOutput("resort_rf", rfPacked(), 32'h87654321);
    checkOutput("resort_swapcnt", 32'(bus.swap_cnt), 32'd25);
    checkOutput("resort_writes", 32'(runWrites), 32'd50);

    // Start held high: one sort, ignored in DONE, re-accepted from IDLE.
    loadRf(32'h99992314);
    applyStimulus(3'd0, 3'd3, 1'b0, 1'b1);
    checkOutput("held_cycles", 32'(runCycles), 32'd15);
    checkOutput("held_swapcnt", 32'(bus.swap_cnt), 32'd4);
    checkOutput("held_idle_after_done", 32'(bus.busy), 32'h0);
    @(negedge CLK);
    checkOutput("held_reaccept_busy", 32'(bus.busy), 32'h1);
    checkOutput("held_reaccept_swapcnt", 32'(bus.swap_cnt), 32'h0);
    bus.start = 1'b0;
    begin
      int k;
      k = -1;
      for (int c = 2; c <= 50 && k < 0; c++) begin
        @(negedge CLK);
        if (bus.done) k = c;
      end
      checkOutput("held_second_cycles", 32'(k), 32'd4);
    end
    checkOutput("held_second_swapcnt", 32'(bus.swap_cnt), 32'h0);
    checkOutput("held_second_rf", rfPacked(), 32'h99994321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
